// File: rtl/compress_pkg.sv
// Shared definitions for the eight-lane compress/decompress path: tag codes,
// flag bit positions, realigner states and the tag-to-byte-length helper.
package compress_pkg;

    localparam int NUM_LANES     = 8;
    localparam int ALIGN_BITS    = 16;
    localparam int TAG_HDR_BYTES = 2;

    localparam logic [1:0] TAG_ZERO = 2'b00;
    localparam logic [1:0] TAG_B1   = 2'b01;
    localparam logic [1:0] TAG_B2   = 2'b10;
    localparam logic [1:0] TAG_RAW  = 2'b11;

    localparam int FLAG_IS_HEADER   = 0;
    localparam int FLAG_COMPRESSION = 1;
    localparam int FLAG_TLAST       = 2;

    typedef enum logic [1:0] {
        R_EMPTY = 2'd0,
        R_HOLD  = 2'd1,
        R_FLUSH = 2'd2
    } realignState_e;

    function automatic logic [2:0] tag_to_len(input logic [1:0] tag);
        case (tag)
            TAG_ZERO: tag_to_len = 3'd0;
            TAG_B1:   tag_to_len = 3'd1;
            TAG_B2:   tag_to_len = 3'd2;
            TAG_RAW:  tag_to_len = 3'd4;
            default:  tag_to_len = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/decompress_unit.sv
// Single-lane expander: turns a tag plus the 4-byte window starting at the
// lane's packed offset into the reconstructed 32-bit word.
module decompress_unit
    import compress_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 2
) (
    input  logic [TAG_WIDTH-1:0]  tag_i,
    input  logic [DATA_WIDTH-1:0] window_i,
    output logic [DATA_WIDTH-1:0] word_o
);

    always_comb begin
        word_o = '0;
        case (tag_i)
            TAG_ZERO: word_o = '0;
            TAG_B1:   word_o = {{(DATA_WIDTH-8){window_i[7]}}, window_i[7:0]};
            TAG_B2:   word_o = {{(DATA_WIDTH-16){window_i[15]}}, window_i[15:0]};
            TAG_RAW:  word_o = window_i;
            default:  word_o = '0;
        endcase
    end

endmodule

// File: rtl/eight_data_decompress_unit.sv
// Packed-beat decompressor: S1 offset/length check, S2 lane expansion, then a
// realigner that undoes the compressor's 16-bit shift of non-header beats.
module eight_data_decompress_unit
    import compress_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 2,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_LANES*TAG_WIDTH-1:0]    in_tag,
    input  logic [LEN_WIDTH-1:0]              in_len,
    input  logic [2:0]                        in_flags,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0]   out_data,
    output logic [2:0]                        out_flags,
    output logic                              out_err
);

    localparam int BEAT_W = NUM_LANES * DATA_WIDTH;
    localparam int IDX_W  = $clog2(BEAT_W);

    logic                          outAdvance;
    logic                          advance;
    logic                          bypass;

    logic                          s1Valid_q;
    logic [BEAT_W-1:0]             s1Data_q;
    logic [NUM_LANES*TAG_WIDTH-1:0] s1Tag_q;
    logic [LEN_WIDTH-1:0]          s1Len_q;
    logic [2:0]                    s1Flags_q;

    logic [5:0]                    laneOffset [NUM_LANES];
    logic [5:0]                    runningSum;
    logic [5:0]                    lenSum;
    logic [LEN_WIDTH-1:0]          expectedLen;
    logic                          lenMismatch;
    logic [BEAT_W-1:0]             expanded;

    logic                          s2Valid_q;
    logic [BEAT_W-1:0]             r_q;
    logic [2:0]                    rFlags_q;

    realignState_e                 state_q, state_d;
    logic [BEAT_W-1:0]             pend_q, pend_d;
    logic [1:0]                    pendFlags_q, pendFlags_d;
    logic                          outValid_q, outValid_d;
    logic [BEAT_W-1:0]             outData_q, outData_d;
    logic [2:0]                    outFlags_q, outFlags_d;
    logic                          err_q, err_d;
    logic                          protoErr;
    logic                          emit;
    logic [BEAT_W-1:0]             emitData;
    logic [2:0]                    emitFlags;

    assign outAdvance = !outValid_q || out_ready;
    assign advance    = outAdvance && (state_q != R_FLUSH);
    assign in_ready   = advance;
    assign bypass     = in_flags[FLAG_IS_HEADER] || !in_flags[FLAG_COMPRESSION];

    // Bypass beats are carried as eight raw lanes so the rest of the pipe is uniform.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1Valid_q <= 1'b0;
            s1Data_q  <= '0;
            s1Tag_q   <= '0;
            s1Len_q   <= '0;
            s1Flags_q <= '0;
        end else if (advance) begin
            s1Valid_q <= in_valid;
            if (in_valid) begin
                s1Data_q  <= in_data;
                s1Tag_q   <= bypass ? '1 : in_tag;
                s1Len_q   <= in_len;
                s1Flags_q <= in_flags;
            end
        end
    end

    always_comb begin
        runningSum = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            laneOffset[i] = runningSum;
            runningSum    = runningSum + 6'(tag_to_len(s1Tag_q[TAG_WIDTH*i +: TAG_WIDTH]));
        end
        lenSum      = runningSum;
        expectedLen = LEN_WIDTH'(lenSum);
        if (s1Flags_q[FLAG_COMPRESSION] && !s1Flags_q[FLAG_IS_HEADER]) begin
            expectedLen = expectedLen + LEN_WIDTH'(TAG_HDR_BYTES);
        end
        lenMismatch = s1Valid_q && (s1Len_q != expectedLen);
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
        logic [IDX_W-1:0] bitIdx;
        assign bitIdx = IDX_W'({laneOffset[g], 3'b000});

        decompress_unit #(
            .DATA_WIDTH (DATA_WIDTH),
            .TAG_WIDTH  (TAG_WIDTH)
        ) uLane (
            .tag_i    (s1Tag_q[TAG_WIDTH*g +: TAG_WIDTH]),
            .window_i (s1Data_q[bitIdx +: DATA_WIDTH]),
            .word_o   (expanded[DATA_WIDTH*g +: DATA_WIDTH])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2Valid_q <= 1'b0;
            r_q       <= '0;
            rFlags_q  <= '0;
        end else if (advance) begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                r_q      <= expanded;
                rFlags_q <= s1Flags_q;
            end
        end
    end

    // Each non-header beat's low 16 bits complete the previous beat's top half.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pendFlags_d = pendFlags_q;
        protoErr    = 1'b0;
        emit        = 1'b0;
        emitData    = '0;
        emitFlags   = '0;

        if (state_q == R_FLUSH) begin
            if (outAdvance) begin
                emit        = 1'b1;
                emitData    = {{ALIGN_BITS{1'b0}}, pend_q[BEAT_W-1:ALIGN_BITS]};
                emitFlags   = {1'b1, pendFlags_q};
                state_d     = R_EMPTY;
                pend_d      = '0;
                pendFlags_d = '0;
            end
        end else if (s2Valid_q && advance) begin
            if (rFlags_q[FLAG_IS_HEADER]) begin
                protoErr    = (state_q != R_EMPTY);
                emit        = 1'b1;
                emitData    = r_q;
                emitFlags   = rFlags_q;
                state_d     = R_EMPTY;
                pend_d      = '0;
                pendFlags_d = '0;
            end else if (state_q == R_EMPTY) begin
                if (rFlags_q[FLAG_TLAST]) begin
                    emit      = 1'b1;
                    emitData  = {{ALIGN_BITS{1'b0}}, r_q[BEAT_W-1:ALIGN_BITS]};
                    emitFlags = rFlags_q;
                end else begin
                    pend_d      = r_q;
                    pendFlags_d = rFlags_q[1:0];
                    state_d     = R_HOLD;
                end
            end else begin
                emit        = 1'b1;
                emitData    = {r_q[ALIGN_BITS-1:0], pend_q[BEAT_W-1:ALIGN_BITS]};
                emitFlags   = {1'b0, pendFlags_q};
                pend_d      = r_q;
                pendFlags_d = rFlags_q[1:0];
                if (rFlags_q[FLAG_TLAST]) begin
                    state_d = R_FLUSH;
                end
            end
        end

        outValid_d = outValid_q;
        outData_d  = outData_q;
        outFlags_d = outFlags_q;
        if (outAdvance) begin
            outValid_d = emit;
            if (emit) begin
                outData_d  = emitData;
                outFlags_d = emitFlags;
            end
        end

        err_d = err_q | lenMismatch | protoErr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= R_EMPTY;
            pend_q      <= '0;
            pendFlags_q <= '0;
            outValid_q  <= 1'b0;
            outData_q   <= '0;
            outFlags_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pendFlags_q <= pendFlags_d;
            outValid_q  <= outValid_d;
            outData_q   <= outData_d;
            outFlags_q  <= outFlags_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_flags = outFlags_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_eight_data_decompress_unit.sv
// Directed bench for eight_data_decompress_unit: beats are packed by a small
// compressor model and expected outputs are queued as each beat is driven.
module tb_eight_data_decompress_unit;

    typedef struct packed {
        logic [255:0] data;
        logic [2:0]   flags;
    } expBeat_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic [15:0]  in_tag;
    logic [7:0]   in_len;
    logic [2:0]   in_flags;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic [2:0]   out_flags;
    logic         out_err;

    int           testsRun = 0;
    int           failCount = 0;
    int           bubbleCount = 0;
    expBeat_t     expQ[$];
    bit           havePrev = 1'b0;
    logic [255:0] prevR = '0;
    bit           randReady = 1'b0;
    bit           readyRand = 1'b1;
    bit           outReadyFixed = 1'b1;

    assign out_ready = randReady ? readyRand : outReadyFixed;

    eight_data_decompress_unit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .in_len    (in_len),
        .in_flags  (in_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [255:0] observed, input logic [255:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
        end
    endtask

    function automatic logic [1:0] tagFor(input logic [31:0] w);
        if (w == 32'h0) return 2'b00;
        if (w == {{24{w[7]}}, w[7:0]}) return 2'b01;
        if (w == {{16{w[15]}}, w[15:0]}) return 2'b10;
        return 2'b11;
    endfunction

    // Compressor model: lane bytes packed back to back from byte 0.
    function automatic void packBeat(input logic [255:0] words, output logic [255:0] data,
                                     output logic [15:0] tags, output logic [7:0] len);
        int ptr;
        int n;
        logic [31:0] w;
        logic [1:0] t;
        ptr = 0;
        data = '0;
        tags = '0;
        for (int i = 0; i < 8; i++) begin
            w = words[32*i +: 32];
            t = tagFor(w);
            n = (t == 2'b00) ? 0 : (t == 2'b01) ? 1 : (t == 2'b10) ? 2 : 4;
            tags[2*i +: 2] = t;
            for (int b = 0; b < n; b++) begin
                data[8*ptr +: 8] = w[8*b +: 8];
                ptr++;
            end
        end
        len = 8'(ptr + 2);
    endfunction

    function automatic logic [255:0] randomWords();
        logic [255:0] w;
        logic [31:0] v;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            case ($urandom_range(0, 3))
                0: v = 32'h0;
                1: v = {{24{v[7]}}, v[7:0]};
                2: v = {{16{v[15]}}, v[15:0]};
                default: v = v;
            endcase
            w[32*i +: 32] = v;
        end
        return w;
    endfunction

    task automatic applyStimulus(input logic [255:0] data, input logic [15:0] tag,
                                 input logic [7:0] len, input logic [2:0] flags);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_data  = data;
        in_tag   = tag;
        in_len   = len;
        in_flags = flags;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        testsRun++;
        assert (in_ready === 1'b1) else begin
            failCount++;
            $error("[TB] FAIL accept_timeout: in_ready %b after %0d cycles, required 1", in_ready, waited);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic sendHeader(input logic [255:0] words);
        expBeat_t e;
        e.data  = words;
        e.flags = 3'b001;
        expQ.push_back(e);
        applyStimulus(words, 16'h0000, 8'd32, 3'b001);
    endtask

    task automatic sendData(input logic [255:0] words, input bit last, input bit badLen);
        logic [255:0] data;
        logic [15:0]  tags;
        logic [7:0]   len;
        expBeat_t     e;
        packBeat(words, data, tags, len);
        if (badLen) len = len + 8'd1;
        if (havePrev) begin
            e.data  = {words[15:0], prevR[255:16]};
            e.flags = 3'b010;
            expQ.push_back(e);
        end
        if (last) begin
            e.data  = {16'h0000, words[255:16]};
            e.flags = 3'b110;
            expQ.push_back(e);
            havePrev = 1'b0;
        end else begin
            prevR    = words;
            havePrev = 1'b1;
        end
        applyStimulus(data, tags, len, {last, 2'b10});
    endtask

    task automatic waitDrain();
        int cycles;
        cycles = 0;
        while (expQ.size() != 0 && cycles < 500) begin
            @(posedge clk);
            cycles++;
        end
        testsRun++;
        assert (expQ.size() == 0) else begin
            failCount++;
            $error("[TB] FAIL drain: %0d beats still outstanding after %0d cycles, required 0", expQ.size(), cycles);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on each handshake and checks holding while stalled.
    initial begin
        bit           wasStalled;
        logic [255:0] heldData;
        logic [2:0]   heldFlags;
        expBeat_t     e;
        wasStalled = 1'b0;
        heldData   = '0;
        heldFlags  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                wasStalled = 1'b0;
            end else begin
                if (wasStalled) begin
                    checkOutput("stall_valid", 256'(out_valid), 256'(1));
                    checkOutput("stall_data", out_data, heldData);
                    checkOutput("stall_flags", 256'(out_flags), 256'(heldFlags));
                end
                if (out_valid && out_ready) begin
                    testsRun++;
                    assert (expQ.size() != 0) else begin
                        failCount++;
                        $error("[TB] FAIL unexpected_beat: observed %h expected none", out_data);
                    end
                    if (expQ.size() != 0) begin
                        e = expQ.pop_front();
                        checkOutput("out_data", out_data, e.data);
                        checkOutput("out_flags", 256'(out_flags), 256'(e.flags));
                    end
                end
                wasStalled = out_valid && !out_ready;
                heldData   = out_data;
                heldFlags  = out_flags;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && !in_ready) bubbleCount++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            readyRand = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [255:0] w;
        int           bubStart;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_tag   = '0;
        in_len   = '0;
        in_flags = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 256'(out_valid), 256'(0));
        checkOutput("reset_out_data", out_data, 256'(0));
        checkOutput("reset_out_flags", 256'(out_flags), 256'(0));
        checkOutput("reset_out_err", 256'(out_err), 256'(0));
        checkOutput("reset_in_ready", 256'(in_ready), 256'(1));
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Header bypass with garbage tags: identical data, 3-cycle latency.
        sendHeader(256'h0123456789ABCDEF_FEDCBA9876543210_0123456789ABCDEF_FEDCBA9876543210);
        @(negedge clk);
        checkOutput("hdr_lat1", 256'(out_valid), 256'(0));
        @(negedge clk);
        checkOutput("hdr_lat2", 256'(out_valid), 256'(0));
        @(negedge clk);
        checkOutput("hdr_lat3", 256'(out_valid), 256'(1));
        waitDrain();

        // All-zero compressed beats: two outputs and exactly one input bubble.
        bubStart = bubbleCount;
        sendData(256'h0, 1'b0, 1'b0);
        sendData(256'h0, 1'b1, 1'b0);
        waitDrain();
        checkOutput("tail_bubble", 256'(bubbleCount - bubStart), 256'(1));

        // Lane 0 byte 8'h80 sign-extended, seven raw lanes behind it (len 31).
        w = '0;
        w[31:0] = 32'hFFFFFF80;
        for (int i = 1; i < 8; i++) w[32*i +: 32] = 32'hA5000000 + 32'(i);
        sendData(w, 1'b0, 1'b0);
        sendData(randomWords(), 1'b1, 1'b0);
        waitDrain();
        checkOutput("err_clean", 256'(out_err), 256'(0));

        // Length off by one sets the sticky error; later good beats do not clear it.
        sendData(randomWords(), 1'b1, 1'b1);
        waitDrain();
        checkOutput("err_set", 256'(out_err), 256'(1));
        sendData(randomWords(), 1'b0, 1'b0);
        sendData(randomWords(), 1'b1, 1'b0);
        waitDrain();
        checkOutput("err_sticky", 256'(out_err), 256'(1));

        // 16-beat packet with out_ready toggling randomly.
        randReady = 1'b1;
        for (int i = 0; i < 16; i++) sendData(randomWords(), i == 15, 1'b0);
        waitDrain();
        randReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while holding a pending beat with more beats in flight.
        sendData(randomWords(), 1'b0, 1'b0);
        sendData(randomWords(), 1'b0, 1'b0);
        sendData(randomWords(), 1'b0, 1'b0);
        @(posedge clk);
        #2;
        checkOutput("hold_valid", 256'(out_valid), 256'(1));
        reset = 1'b1;
        #1;
        checkOutput("rst_out_valid", 256'(out_valid), 256'(0));
        checkOutput("rst_out_data", out_data, 256'(0));
        checkOutput("rst_out_err", 256'(out_err), 256'(0));
        expQ.delete();
        havePrev = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        sendHeader(randomWords());
        waitDrain();
        sendData(randomWords(), 1'b0, 1'b0);
        sendData(randomWords(), 1'b1, 1'b0);
        waitDrain();
        checkOutput("post_rst_err", 256'(out_err), 256'(0));

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
